// File: rtl/data_capture_if.sv
// Bus-side bundle for data_capture: read-cycle capture controls in, captured
// registers and one-cycle event pulses out.
interface data_capture_if;
  logic [7:0]  data_in;
  logic        rw;
  logic        ready;
  logic        cap_en;
  logic [2:0]  cap_sel;
  logic [7:0]  ir;
  logic [15:0] addr;
  logic [7:0]  dl;
  logic        ir_valid;
  logic        addr_valid;
  logic        dl_valid;
  logic        busy;
  logic        abort;
  logic        wr_conflict;
  logic        sm_state;

  modport master (
    output data_in, rw, ready, cap_en, cap_sel,
    input  ir, addr, dl, ir_valid, addr_valid, dl_valid, busy, abort,
           wr_conflict, sm_state
  );

  modport slave (
    input  data_in, rw, ready, cap_en, cap_sel,
    output ir, addr, dl, ir_valid, addr_valid, dl_valid, busy, abort,
           wr_conflict, sm_state
  );
endinterface

// File: rtl/data_capture.sv
// Read-direction bus capture: steers sampled data bytes into ir/addr/dl and
// assembles little-endian operand addresses with a two-byte sequencer.
module data_capture #(
  parameter logic [7:0]  IR_RESET   = 8'h00,
  parameter logic [15:0] ADDR_RESET = 16'h0000
) (
  input  logic           clk,
  input  logic           rst,
  data_capture_if.slave  bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    WORD_HI = 1'b1
  } state_t;

  // Handshake: a byte is taken on a rising edge only when cap_en, rw (read)
  // and ready are all high; ready=0 stretches the cycle and freezes everything.
  localparam logic [2:0] SEL_IR   = 3'd1;
  localparam logic [2:0] SEL_ADL  = 3'd2;
  localparam logic [2:0] SEL_ADH  = 3'd3;
  localparam logic [2:0] SEL_DL   = 3'd4;
  localparam logic [2:0] SEL_WORD = 3'd5;

  state_t      state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  dl_q, dl_d;
  logic        ir_valid_q, ir_valid_d;
  logic        addr_valid_q, addr_valid_d;
  logic        dl_valid_q, dl_valid_d;
  logic        abort_q, abort_d;
  logic        wr_conflict_q, wr_conflict_d;
  logic        cap;

  assign cap = bus.cap_en & bus.rw & bus.ready;

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    addr_d        = addr_q;
    dl_d          = dl_q;
    ir_valid_d    = 1'b0;
    addr_valid_d  = 1'b0;
    dl_valid_d    = 1'b0;
    abort_d       = 1'b0;
    wr_conflict_d = bus.cap_en & bus.ready & ~bus.rw;

    if (cap) begin
      case (bus.cap_sel)
        SEL_IR: begin
          ir_d       = bus.data_in;
          ir_valid_d = 1'b1;
        end
        SEL_ADL, SEL_ADH: begin
          if (bus.cap_sel == SEL_ADL) addr_d[7:0]  = bus.data_in;
          else                        addr_d[15:8] = bus.data_in;
          // An explicit address byte overrides any half-built word.
          if (state_q == WORD_HI) begin
            state_d = IDLE;
            abort_d = 1'b1;
          end
        end
        SEL_DL: begin
          dl_d       = bus.data_in;
          dl_valid_d = 1'b1;
        end
        SEL_WORD: begin
          if (state_q == IDLE) begin
            addr_d[7:0] = bus.data_in;
            state_d     = WORD_HI;
          end else begin
            addr_d[15:8] = bus.data_in;
            state_d      = IDLE;
            addr_valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ir_q          <= IR_RESET;
      addr_q        <= ADDR_RESET;
      dl_q          <= 8'h00;
      ir_valid_q    <= 1'b0;
      addr_valid_q  <= 1'b0;
      dl_valid_q    <= 1'b0;
      abort_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      addr_q        <= addr_d;
      dl_q          <= dl_d;
      ir_valid_q    <= ir_valid_d;
      addr_valid_q  <= addr_valid_d;
      dl_valid_q    <= dl_valid_d;
      abort_q       <= abort_d;
      wr_conflict_q <= wr_conflict_d;
    end
  end

  assign bus.ir          = ir_q;
  assign bus.addr        = addr_q;
  assign bus.dl          = dl_q;
  assign bus.ir_valid    = ir_valid_q;
  assign bus.addr_valid  = addr_valid_q;
  assign bus.dl_valid    = dl_valid_q;
  assign bus.abort       = abort_q;
  assign bus.wr_conflict = wr_conflict_q;
  assign bus.busy        = (state_q == WORD_HI);
  assign bus.sm_state    = state_q;

endmodule

// File: tb/tb_data_capture.sv
// Bench for data_capture: directed bus cycles, a per-cycle reference model
// comparison, and literal checks on the scripted scenarios.
module tb_data_capture;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_capture_if bus ();

  data_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  ir;
    logic [15:0] addr;
    logic [7:0]  dl;
    logic        half;
    logic        irv;
    logic        av;
    logic        dlv;
    logic        ab;
    logic        wc;
  } mstate_t;

  mstate_t m;

  // Reference: what a bus cycle does to the visible registers and pulses.
  function automatic mstate_t model_next(mstate_t s, logic en, logic rw,
                                         logic rdy, logic [2:0] sel,
                                         logic [7:0] d);
    mstate_t n;
    n     = s;
    n.irv = 1'b0;
    n.av  = 1'b0;
    n.dlv = 1'b0;
    n.ab  = 1'b0;
    n.wc  = 1'b0;
    if (!rdy || !en) return n;
    if (!rw) begin
      n.wc = 1'b1;
      return n;
    end
    if (sel == 3'd1) begin
      n.ir = d; n.irv = 1'b1;
    end else if (sel == 3'd4) begin
      n.dl = d; n.dlv = 1'b1;
    end else if (sel == 3'd2 || sel == 3'd3) begin
      n.addr = (sel == 3'd2) ? {s.addr[15:8], d} : {d, s.addr[7:0]};
      n.ab   = s.half;
      n.half = 1'b0;
    end else if (sel == 3'd5) begin
      if (!s.half) begin
        n.addr = {s.addr[15:8], d};
        n.half = 1'b1;
      end else begin
        n.addr = {d, s.addr[7:0]};
        n.half = 1'b0;
        n.av   = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '0;
    else     m <= model_next(m, bus.cap_en, bus.rw, bus.ready, bus.cap_sel, bus.data_in);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_ir",   {8'h00, bus.ir},        {8'h00, m.ir});
      chk("cmp_addr", bus.addr,               m.addr);
      chk("cmp_dl",   {8'h00, bus.dl},        {8'h00, m.dl});
      chk("cmp_busy", {15'h0, bus.busy},      {15'h0, m.half});
      chk("cmp_pulses",
          {11'h0, bus.ir_valid, bus.addr_valid, bus.dl_valid, bus.abort, bus.wr_conflict},
          {11'h0, m.irv, m.av, m.dlv, m.ab, m.wc});
    end
  end

  // Drive one bus cycle, then return just after the edge that consumes it.
  task automatic step(input logic en, input logic rw, input logic rdy,
                      input logic [2:0] sel, input logic [7:0] d);
    bus.cap_en  = en;
    bus.rw      = rw;
    bus.ready   = rdy;
    bus.cap_sel = sel;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b1, 3'd0, 8'h00);
  endtask

  task automatic chk_pulses(input string name, input logic [4:0] exp);
    chk(name, {11'h0, bus.ir_valid, bus.addr_valid, bus.dl_valid, bus.abort, bus.wr_conflict},
        {11'h0, exp});
  endtask

  int av_count;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.cap_en = 1'b0; bus.rw = 1'b1; bus.ready = 1'b1;
    bus.cap_sel = 3'd0; bus.data_in = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset mid-word discards the pending low byte
    step(1, 1, 1, 3'd5, 8'h34);
    chk("t1_busy_set", {15'h0, bus.busy}, 16'h0001);
    chk("t1_addr_lo", bus.addr, 16'h0034);
    rst = 1'b1;
    #1;
    chk("t1_rst_addr", bus.addr, 16'h0000);
    chk("t1_rst_ir", {8'h00, bus.ir}, 16'h0000);
    chk("t1_rst_dl", {8'h00, bus.dl}, 16'h0000);
    chk("t1_rst_busy", {15'h0, bus.busy}, 16'h0000);
    chk_pulses("t1_rst_pulses", 5'b00000);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 1, 1, 3'd5, 8'h12);
    chk("t1_restart_lo", bus.addr, 16'h0012);
    chk("t1_restart_busy", {15'h0, bus.busy}, 16'h0001);
    step(1, 1, 1, 3'd5, 8'h00);
    idle();

    // Two-byte word
    step(1, 1, 1, 3'd5, 8'h34);
    chk("t2_busy", {15'h0, bus.busy}, 16'h0001);
    chk_pulses("t2_no_pulse", 5'b00000);
    step(1, 1, 1, 3'd5, 8'h12);
    chk("t2_addr", bus.addr, 16'h1234);
    chk_pulses("t2_av", 5'b01000);
    chk("t2_busy_clr", {15'h0, bus.busy}, 16'h0000);
    idle();
    chk_pulses("t2_av_once", 5'b00000);

    // Stall in WORD_HI with capture requests
    step(1, 1, 1, 3'd5, 8'hAB);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 3'd5, 8'hFF);
      chk("t3_stall_busy", {15'h0, bus.busy}, 16'h0001);
      chk("t3_stall_addr", bus.addr, 16'h12AB);
      chk_pulses("t3_stall_pulses", 5'b00000);
    end
    repeat (4) idle();
    chk("t3_idle_busy", {15'h0, bus.busy}, 16'h0001);
    step(1, 1, 1, 3'd5, 8'hCD);
    chk("t3_addr", bus.addr, 16'hCDAB);
    chk_pulses("t3_av", 5'b01000);

    // Explicit address byte aborts a word; opcode capture
    step(1, 1, 1, 3'd5, 8'h34);
    step(1, 1, 1, 3'd2, 8'h56);
    chk("t4_addr", bus.addr, 16'hCD56);
    chk_pulses("t4_abort", 5'b00010);
    chk("t4_busy", {15'h0, bus.busy}, 16'h0000);
    step(1, 1, 1, 3'd1, 8'hA9);
    chk("t4_ir", {8'h00, bus.ir}, 16'h00A9);
    chk_pulses("t4_irv", 5'b10000);
    step(1, 1, 1, 3'd5, 8'h11);
    step(1, 1, 1, 3'd4, 8'h22);
    chk("t4_dl_in_word_busy", {15'h0, bus.busy}, 16'h0001);
    step(1, 1, 1, 3'd3, 8'h99);
    chk("t4_adh_abort_addr", bus.addr, 16'h9911);
    chk_pulses("t4_adh_abort", 5'b00010);

    // Write-cycle conflict
    step(1, 0, 1, 3'd4, 8'h77);
    chk("t5_dl", {8'h00, bus.dl}, 16'h0022);
    chk_pulses("t5_wc", 5'b00001);
    step(1, 0, 0, 3'd4, 8'h77);
    chk_pulses("t5_wc_stalled", 5'b00000);

    // Reserved selects, then a real dl capture
    step(1, 1, 1, 3'd6, 8'h11);
    step(1, 1, 1, 3'd7, 8'h22);
    step(1, 1, 1, 3'd0, 8'h33);
    chk_pulses("t6_reserved", 5'b00000);
    chk("t6_addr", bus.addr, 16'h9911);
    step(1, 1, 1, 3'd4, 8'h77);
    chk("t6_dl", {8'h00, bus.dl}, 16'h0077);
    chk_pulses("t6_dlv", 5'b00100);

    // Back-to-back words
    av_count = 0;
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 1, 3'd5, 8'(i));
      if (bus.addr_valid) av_count++;
    end
    chk("t7_av_count", 16'(av_count), 16'd2);
    chk("t7_addr", bus.addr, 16'h0403);

    // Randomised tail cross-checked by the per-cycle comparison
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           8'($urandom_range(0, 255)));
    end
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
